// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
//   Each frame runs IDLE -> ISSUE -> WAIT_DONE -> IDLE. If the TX engine
//   never reports completion, the frame is dropped after TIMEOUT_CYC cycles.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst          : asynchronous, active-high reset
//   en           : allows new grants; a frame already started always runs to its end
//   req[N_REQ]   : per-requester transmit request, held until its gnt
//   data[8*N_REQ]: per-requester byte; requester i drives bits [8i+7:8i]
//   gnt[N_REQ]   : one-hot, one-cycle grant pulse (coincident with tx_start)
//   tx_start     : one-cycle start pulse to the TX engine
//   tx_data[8]   : byte latched at grant time, held until the next grant
//   tx_done      : end-of-frame pulse from the TX engine
//   busy         : high whenever a frame is in flight (state != IDLE)
//   cur_id[3]    : index of the most recently granted requester
//   err_timeout  : one-cycle pulse when a frame is aborted by timeout
module uart_tx_arb #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic               busy,
    output logic [2:0]         cur_id,
    output logic               err_timeout
);

    localparam int                 PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0]        CNT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0]   GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [2:0]       cur_id_q, cur_id_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_d;

    // Per-requester byte lanes.
    logic [7:0] data_bytes [N_REQ];
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign data_bytes[gi] = data[8*gi +: 8];
        end
    endgenerate

    // Winner search: scan upward from ptr, wrapping, first set bit wins.
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] ptr_after_win;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_after_win = PTR_W'((int'(win_idx) + 1) % N_REQ);

    // Next-state and Moore outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_id_d  = cur_id_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        gnt       = '0;
        tx_start  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && win_found) begin
                    state_d   = ISSUE;
                    cur_id_d  = 3'(win_idx);
                    tx_data_d = data_bytes[win_idx];
                    ptr_d     = ptr_after_win;
                end
            end
            ISSUE: begin
                // tx_done is deliberately ignored here.
                tx_start = 1'b1;
                gnt      = GNT_ONE << cur_id_q;
                cnt_d    = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done is checked first so it wins over a coincident timeout.
                if (tx_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign cur_id      = cur_id_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
//   Two instances share all inputs: dut_a uses the default timeout (never
//   expires in these tests), dut_b uses TIMEOUT_CYC=8 so the timeout paths
//   are exercised on the same traffic. Table-driven frames, hand-written
//   corner sequences, then randomized frames checked against a request-level
//   model (pending set, round-robin pointer, per-requester bytes).
module tb_uart_tx_arb;

    localparam int TO_B = 8;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] data;
    logic        tx_done;

    logic [3:0] gnt_a, gnt_b;
    logic       tx_start_a, tx_start_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       busy_a, busy_b;
    logic [2:0] cur_id_a, cur_id_b;
    logic       err_a, err_b;

    int checks   = 0;
    int failures = 0;

    uart_tx_arb #(.N_REQ(4), .TIMEOUT_CYC(65535)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
        .gnt(gnt_a), .tx_start(tx_start_a), .tx_data(tx_data_a),
        .tx_done(tx_done), .busy(busy_a), .cur_id(cur_id_a),
        .err_timeout(err_a)
    );

    uart_tx_arb #(.N_REQ(4), .TIMEOUT_CYC(TO_B)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
        .gnt(gnt_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .tx_done(tx_done), .busy(busy_b), .cur_id(cur_id_b),
        .err_timeout(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge; all driving and
    // sampling happens there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = '0; tx_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // One complete frame starting with both DUTs idle. dly = cycle index in
    // WAIT_DONE (0 = first cycle) on which tx_done is pulsed.
    task automatic run_frame(input logic [3:0] req_v, input logic [31:0] data_v,
                             input logic [3:0] exp_gnt, input logic [2:0] exp_id,
                             input logic [7:0] exp_data, input int dly,
                             input logic issue_done);
        int   end_b;
        logic to_b;
        to_b  = (dly > TO_B - 1);
        end_b = to_b ? TO_B - 1 : dly;
        $display("frame req=%b data=%h exp_gnt=%b exp_id=%0d exp_data=%h dly=%0d b_timeout=%0d",
                 req_v, data_v, exp_gnt, exp_id, exp_data, dly, to_b);
        en = 1'b1; req = req_v; data = data_v; tx_done = 1'b0;
        tick();
        chk("gnt_a", gnt_a, exp_gnt);
        chk("gnt_b", gnt_b, exp_gnt);
        chk("tx_start_a", tx_start_a, 1);
        chk("tx_start_b", tx_start_b, 1);
        chk("tx_data_a", tx_data_a, exp_data);
        chk("tx_data_b", tx_data_b, exp_data);
        chk("cur_id_a", cur_id_a, exp_id);
        chk("cur_id_b", cur_id_b, exp_id);
        chk("busy_issue_a", busy_a, 1);
        // Requester drops its request, changes its byte; en drops mid-frame.
        en = 1'b0;
        req = req_v & ~exp_gnt;
        data[8*exp_id +: 8] = ~exp_data;
        tx_done = issue_done;
        tick();
        for (int c = 0; c <= dly + 1; c++) begin
            tx_done = (c == dly);
            chk("wait_busy_a", busy_a, (c <= dly));
            chk("wait_err_a", err_a, 0);
            chk("wait_busy_b", busy_b, (c <= end_b));
            chk("wait_err_b", err_b, (to_b && c == end_b + 1));
            chk("wait_gnt_a", gnt_a, 0);
            chk("wait_start_b", tx_start_b, 0);
            if (c <= dly) tick();
        end
        tx_done = 1'b0;
        chk("hold_tx_data_a", tx_data_a, exp_data);
        chk("hold_tx_data_b", tx_data_b, exp_data);
        chk("hold_cur_id_a", cur_id_a, exp_id);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [2:0] exp_id;
        logic [7:0] exp_data;
        int         dly;
        logic       issue_done;
    } vec_t;

    vec_t tbl [8];

    // Reference model state for the random phase.
    logic [3:0] pend;
    logic [3:0] newb;
    logic [7:0] bytes_m [4];
    int         ptr_m;
    int         w;
    int         dly_r;

    initial begin
        // Round-robin 0,1,2,3,0 with each grant's bit dropped for one frame,
        // then skip to 2 (ptr -> 3), then wrap-and-skip: grant 0, then 1.
        // Byte lanes: 0=11 1=22 2=33 3=44.
        tbl[0] = '{4'b1111, 4'b0001, 3'd0, 8'h11, 2,  1'b0};
        tbl[1] = '{4'b1110, 4'b0010, 3'd1, 8'h22, 7,  1'b1};
        tbl[2] = '{4'b1101, 4'b0100, 3'd2, 8'h33, 0,  1'b0};
        tbl[3] = '{4'b1011, 4'b1000, 3'd3, 8'h44, 11, 1'b1};
        tbl[4] = '{4'b0111, 4'b0001, 3'd0, 8'h11, 4,  1'b0};
        tbl[5] = '{4'b0100, 4'b0100, 3'd2, 8'h33, 1,  1'b0};
        tbl[6] = '{4'b0011, 4'b0001, 3'd0, 8'h11, 3,  1'b1};
        tbl[7] = '{4'b0010, 4'b0010, 3'd1, 8'h22, 5,  1'b0};

        rst = 1'b1; en = 1'b0; req = '0; data = '0; tx_done = 1'b0;
        tick();
        // Reset values.
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_start_a", tx_start_a, 0);
        chk("rst_tx_data_a", tx_data_a, 8'h00);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_cur_id_a", cur_id_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_busy_b", busy_b, 0);
        tick();
        rst = 1'b0;

        // Single request, tx_done 10 cycles after tx_start.
        run_frame(4'b0100, 32'h00A5_0000, 4'b0100, 3'd2, 8'hA5, 9, 1'b0);

        // Table-driven round-robin / wrap / timeout frames.
        do_reset();
        for (int i = 0; i < 8; i++)
            run_frame(tbl[i].req, 32'h4433_2211, tbl[i].exp_gnt, tbl[i].exp_id,
                      tbl[i].exp_data, tbl[i].dly, tbl[i].issue_done);

        // en gating: 20 cycles of a request with en low, then a grant.
        do_reset();
        req = 4'b0001; data = 32'h0000_005A;
        for (int i = 0; i < 20; i++) begin
            chk("en_gate_gnt_a", gnt_a, 0);
            chk("en_gate_busy_a", busy_a, 0);
            tick();
        end
        run_frame(4'b0001, 32'h0000_005A, 4'b0001, 3'd0, 8'h5A, 3, 1'b0);

        // Back-to-back with en held: one IDLE cycle between frames.
        do_reset();
        en = 1'b1; req = 4'b0011; data = 32'h4433_2211;
        tick();
        chk("b2b_gnt0", gnt_a, 4'b0001);
        req = 4'b0010;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("b2b_idle_busy", busy_a, 0);
        chk("b2b_idle_gnt", gnt_a, 0);
        tick();
        chk("b2b_gnt1", gnt_a, 4'b0010);
        chk("b2b_gnt1_b", gnt_b, 4'b0010);
        chk("b2b_data1", tx_data_a, 8'h22);
        req = '0; en = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("b2b_end_busy", busy_a, 0);

        // Asynchronous reset in the middle of WAIT_DONE.
        do_reset();
        en = 1'b1; req = 4'b1000; data = 32'hCC00_0000;
        tick();
        chk("arst_gnt", gnt_a, 4'b1000);
        req = '0; en = 1'b0;
        tick(); tick();
        chk("arst_busy_pre", busy_a, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy_a", busy_a, 0);
        chk("arst_busy_b", busy_b, 0);
        chk("arst_tx_data", tx_data_a, 8'h00);
        chk("arst_cur_id", cur_id_a, 0);
        tick();
        chk("arst_err_a", err_a, 0);
        chk("arst_err_b", err_b, 0);
        chk("arst_gnt_a", gnt_a, 0);
        chk("arst_start_a", tx_start_a, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("post_arst_err_b", err_b, 0);
            chk("post_arst_gnt_a", gnt_a, 0);
            tick();
        end
        // First arbitration after reset starts from requester 0.
        run_frame(4'b1111, 32'h4433_2211, 4'b0001, 3'd0, 8'h11, 2, 1'b0);

        // Randomized frames against the request-level model.
        do_reset();
        pend  = '0;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) bytes_m[i] = 8'h00;
        for (int f = 0; f < 40; f++) begin
            newb = 4'($urandom_range(0, 15)) & ~pend;
            if ((pend | newb) == 4'b0000) newb = 4'b0001 << $urandom_range(0, 3);
            for (int i = 0; i < 4; i++)
                if (newb[i]) bytes_m[i] = 8'($urandom);
            pend = pend | newb;
            // Smallest pending index at or above ptr, else smallest overall.
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && i >= ptr_m && pend[i]) w = i;
            for (int i = 0; i < 4; i++)
                if (w < 0 && pend[i]) w = i;
            dly_r = $urandom_range(0, 11);
            run_frame(pend, {bytes_m[3], bytes_m[2], bytes_m[1], bytes_m[0]},
                      4'b0001 << w, 3'(w), bytes_m[w], dly_r, 1'($urandom_range(0, 1)));
            pend[w] = 1'b0;
            ptr_m   = (w + 1) % 4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 65535, SHALL set the maximum number of cycles to wait for tx_done before aborting (1..65535).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  input  1  SHALL enable new grants when high; it does not abort a frame in progress.
REQ-006 req  input  N_REQ  SHALL carry per-requester transmit requests, held high until the matching gnt.
REQ-007 data  input  8*N_REQ  SHALL carry the per-requester byte; requester i uses bits [8i+7:8i], stable while req[i] is high.
REQ-008 gnt  output  N_REQ  SHALL be a one-hot, one-cycle acceptance pulse to the winning requester.
REQ-009 tx_start  output  1  SHALL be a one-cycle start pulse to the TX engine.
REQ-010 tx_data  output  8  SHALL carry the byte presented to the TX engine.
REQ-011 tx_done  input  1  SHALL be the TX engine's end-of-frame pulse.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 cur_id  output  3  SHALL give the index of the most recently granted requester.
REQ-014 err_timeout  output  1  SHALL be a one-cycle pulse when a frame is aborted by timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and WAIT_DONE, encoded in registers.
REQ-016 IDLE SHALL go to ISSUE when en=1 and req is nonzero; otherwise it stays in IDLE.
REQ-017 On the IDLE->ISSUE edge the block SHALL register the winner index into cur_id and the winner's byte into tx_data.
REQ-018 The winner SHALL be the first set req bit found by scanning upward from the round-robin pointer ptr, wrapping from N_REQ-1 to 0.
REQ-019 ptr SHALL update to (winner+1) mod N_REQ on the same edge as the winner is registered.
REQ-020 In ISSUE, for exactly one cycle, tx_start SHALL be 1 and gnt[cur_id] SHALL be 1; the next state is WAIT_DONE.
REQ-021 Request-to-start latency SHALL be 1 cycle after the req is sampled in IDLE, and gnt SHALL be coincident with tx_start.
REQ-022 In WAIT_DONE a 16-bit counter SHALL start from 0 on entry and increment each cycle.
REQ-023 tx_done=1 in WAIT_DONE SHALL cause a return to IDLE on the next edge with no error.
REQ-024 When the counter reaches TIMEOUT_CYC-1 without tx_done, the block SHALL return to IDLE and assert err_timeout for 1 cycle.
REQ-025 If tx_done and the timeout terminal count coincide, tx_done SHALL win and err_timeout SHALL stay 0.
REQ-026 tx_done seen in IDLE or ISSUE SHALL be ignored.
REQ-027 Changes to req, data or en after the IDLE->ISSUE edge SHALL NOT affect tx_data or the current frame.
REQ-028 tx_data and cur_id SHALL hold their values until the next grant.
REQ-029 After completion the block SHALL spend at least one cycle in IDLE before the next ISSUE, giving a minimum period of 3 cycles plus the TX time.
REQ-030 Deasserting en in ISSUE or WAIT_DONE SHALL let the frame complete normally.

Reset
REQ-031 While rst=1 the block SHALL immediately force: state IDLE, gnt=0, tx_start=0, tx_data=8'h00, busy=0, cur_id=0, ptr=0, err_timeout=0, counter=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no tx_start, gnt or err_timeout pulse generated.
REQ-033 After rst falls, the first arbitration SHALL start from ptr=0.

Verification
REQ-034 Single request: after reset, req=4'b0100, data[23:16]=8'hA5; next cycle gnt=4'b0100, tx_start=1, tx_data=8'hA5, cur_id=2; tx_done 10 cycles later -> busy=0 one cycle after tx_done.
REQ-035 Round-robin: req=4'b1111 held, each grant dropping the granted bit's request for one frame then reasserting it -> grant order 0,1,2,3,0.
REQ-036 Wrap and skip: ptr=3, req=4'b0011 -> grant 0, then grant 1.
REQ-037 Timeout: TIMEOUT_CYC=8, no tx_done -> err_timeout pulses exactly 8 cycles after entering WAIT_DONE, state returns to IDLE; tx_done on the same terminal cycle -> no err_timeout.
REQ-038 en gating: en=0 with req=4'b0001 -> no gnt for 20 cycles; en=1 -> gnt next cycle; en dropped in WAIT_DONE -> frame completes on tx_done.
REQ-039 Async reset mid-WAIT_DONE: rst pulsed between clock edges -> busy=0 and tx_data=8'h00 before the next edge; no gnt or err_timeout.
